// File: rtl/data_memory_hs.sv
// Word-organised data memory with req/ready handshake, byte strobes, wait states and range flag.
// Latency: done is high WAIT_STATES+1 cycles after acceptance; one request outstanding at a time.
module data_memory_hs #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter bit BYTE_ADDR   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   data_out
);
  localparam int NB    = DATA_W / 8;
  localparam int SHIFT = (BYTE_ADDR && NB > 1) ? $clog2(NB) : 0;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              wr_q, oor_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] din_q;
  logic [NB-1:0]     be_q;

  logic [ADDR_W-1:0] addr_idx;
  logic              addr_oor, accept, access;
  logic              cur_wr, cur_oor;
  logic [IW-1:0]     cur_idx;
  logic [DATA_W-1:0] cur_din;
  logic [NB-1:0]     cur_be;

  logic [DATA_W-1:0] mem [DEPTH];

  // Range check uses the full-width index so high address bits can never alias into the array.
  assign addr_idx = address >> SHIFT;
  assign addr_oor = (addr_idx >= ADDR_W'(DEPTH));

  assign ready  = (state == IDLE) && rst_n;
  assign accept = req && ready;
  assign done   = (state == RESP);
  assign err    = done && oor_q;

  // With zero wait states the access happens on the acceptance edge, so use live inputs then.
  assign cur_wr  = (state == IDLE) ? wr : wr_q;
  assign cur_oor = (state == IDLE) ? addr_oor : oor_q;
  assign cur_idx = (state == IDLE) ? addr_idx[IW-1:0] : idx_q;
  assign cur_din = (state == IDLE) ? data_in : din_q;
  assign cur_be  = (state == IDLE) ? be : be_q;
  assign access  = (state_d == RESP) && (state != RESP);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
          cnt_d   = WS_LOAD;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = RESP;
        else             cnt_d   = cnt - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wr_q     <= 1'b0;
      oor_q    <= 1'b0;
      idx_q    <= '0;
      din_q    <= '0;
      be_q     <= '0;
      data_out <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        wr_q  <= wr;
        oor_q <= addr_oor;
        idx_q <= addr_idx[IW-1:0];
        din_q <= data_in;
        be_q  <= be;
      end
      if (access && !cur_wr) data_out <= cur_oor ? '0 : mem[cur_idx];
    end
  end

  // Array has no reset; access is already gated off while rst_n is low.
  always_ff @(posedge clk) begin
    if (access && cur_wr && !cur_oor) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_din[8*i +: 8];
      end
    end
  end
endmodule
